// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the SRAM controller (clock/reset stay plain ports).
interface ahb_sram_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite SRAM slave: byte-lane writes, wait states, two-cycle ERROR, write-to-read forwarding.
// Define SRAM_PARITY_EN to store per-byte even parity and answer ERROR on read parity faults.
module ahb_sram_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ahb_sram_ctrl_if.slave bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [NB-1:0][7:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                state;
  logic                  ready_q, resp_q, dp_wr, pend_vld, perr;
  logic [1:0]            cnt;
  logic [ADDR_WIDTH-1:0] a_idx, dp_idx, pend_idx;
  logic [NB-1:0]         a_lanes, dp_lanes, pend_lanes, fwd_lanes, f_lanes;
  logic [LB-1:0]         a_off;
  logic                  a_err, accept, rd_en, wr_fin, hready_o;
  word_t                 wdata, pend_data, fwd_data, f_data, rd_raw, hrdata;
  word_t                 mem [DEPTH];
  logic                  unused_bits;

  assign wdata    = bus.HWDATA;
  assign a_idx    = bus.HADDR[ADDR_WIDTH+LB-1:LB];
  assign a_off    = bus.HADDR[LB-1:0];
  assign hready_o = ready_q & ~perr;
  assign accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hready_o;
  assign rd_en    = accept & ~bus.HWRITE & ~a_err;
  assign wr_fin   = dp_wr & hready_o;
  assign unused_bits = ^{bus.HADDR[31:ADDR_WIDTH+LB], bus.HTRANS[0]};

  always_comb begin
    a_lanes = '0;
    a_err   = (bus.HSIZE > 3'(LB)) || (|(a_off & ((LB'(1) << bus.HSIZE) - LB'(1))));
    for (int b = 0; b < NB; b++)
      if (b >= int'(a_off) && b < int'(a_off) + (1 << bus.HSIZE)) a_lanes[b] = 1'b1;
  end

  // A read accepted on the same edge the SRAM is being written sees old data;
  // patch in the committing pending write, then the write completing right now.
  always_comb begin
    f_data  = pend_data;
    f_lanes = (pend_vld && pend_idx == a_idx) ? pend_lanes : '0;
    for (int b = 0; b < NB; b++)
      if (wr_fin && dp_idx == a_idx && dp_lanes[b]) begin
        f_data[b]  = wdata[b];
        f_lanes[b] = 1'b1;
      end
  end

  always_ff @(posedge HCLK) begin
    if (pend_vld && !HRESET)
      for (int b = 0; b < NB; b++)
        if (pend_lanes[b]) mem[pend_idx][b] <= pend_data[b];
    if (HRESET)     rd_raw <= '0;
    else if (rd_en) rd_raw <= mem[a_idx];
  end

  always_comb
    for (int b = 0; b < NB; b++) hrdata[b] = fwd_lanes[b] ? fwd_data[b] : rd_raw[b];

  assign bus.HRDATA    = hrdata;
  assign bus.HREADYOUT = hready_o;
  assign bus.HRESP     = resp_q | perr;

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_q;
  logic          chk;

  always_ff @(posedge HCLK) begin
    if (pend_vld && !HRESET)
      for (int b = 0; b < NB; b++)
        if (pend_lanes[b]) par_mem[pend_idx][b] <= ^pend_data[b];
    if (HRESET) begin
      par_q <= '0;
      chk   <= 1'b0;
    end else begin
      if (rd_en) par_q <= par_mem[a_idx];
      chk <= rd_en;
    end
  end

  // Only lanes actually read from the array are checked; forwarded bytes are fresh.
  always_comb begin
    perr = 1'b0;
    for (int b = 0; b < NB; b++)
      if (chk && dp_lanes[b] && !fwd_lanes[b] && ((^rd_raw[b]) != par_q[b])) perr = 1'b1;
  end
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= S_IDLE;
      ready_q    <= 1'b1;
      resp_q     <= 1'b0;
      cnt        <= '0;
      dp_wr      <= 1'b0;
      dp_idx     <= '0;
      dp_lanes   <= '0;
      pend_vld   <= 1'b0;
      pend_idx   <= '0;
      pend_lanes <= '0;
      pend_data  <= '0;
      fwd_lanes  <= '0;
      fwd_data   <= '0;
    end else begin
      pend_vld <= wr_fin;
      if (wr_fin) begin
        pend_idx   <= dp_idx;
        pend_lanes <= dp_lanes;
        pend_data  <= wdata;
      end
      if (accept) begin
        dp_idx   <= a_idx;
        dp_lanes <= a_lanes;
        dp_wr    <= bus.HWRITE & ~a_err;
      end else if (hready_o) begin
        dp_wr <= 1'b0;
      end
      if (rd_en) begin
        fwd_data  <= f_data;
        fwd_lanes <= f_lanes;
      end
      case (state)
        S_WAIT: begin
          if (perr) begin
            state   <= S_ERR2;
            ready_q <= 1'b1;
            resp_q  <= 1'b1;
          end else if (cnt == 2'(WAIT_STATES - 1)) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          // perr here acts as the first ERROR cycle, so jump straight to the second
          if (perr) begin
            state   <= S_ERR2;
            ready_q <= 1'b1;
            resp_q  <= 1'b1;
          end else if (accept && a_err) begin
            state   <= S_ERR1;
            ready_q <= 1'b0;
            resp_q  <= 1'b1;
          end else if (accept && WAIT_STATES > 0) begin
            state   <= S_WAIT;
            ready_q <= 1'b0;
            resp_q  <= 1'b0;
            cnt     <= '0;
          end else begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: directed plan cases plus random traffic against a byte-array model,
// on a zero-wait instance and a two-wait-state instance.
module tb_ahb_sram_ctrl;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_sram_ctrl_if #(.DATA_WIDTH(DW)) b0 ();
  ahb_sram_ctrl_if #(.DATA_WIDTH(DW)) b2 ();

  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  int          cur;

  assign b0.HSEL   = hsel & (cur == 0);
  assign b2.HSEL   = hsel & (cur == 1);
  assign b0.HADDR  = haddr;  assign b2.HADDR  = haddr;
  assign b0.HTRANS = htrans; assign b2.HTRANS = htrans;
  assign b0.HWRITE = hwrite; assign b2.HWRITE = hwrite;
  assign b0.HSIZE  = hsize;  assign b2.HSIZE  = hsize;
  assign b0.HWDATA = hwdata; assign b2.HWDATA = hwdata;
  assign b0.HREADY = b0.HREADYOUT;
  assign b2.HREADY = b2.HREADYOUT;

  logic        rdy, rsp;
  logic [31:0] rdat;
  assign rdy  = (cur == 1) ? b2.HREADYOUT : b0.HREADYOUT;
  assign rsp  = (cur == 1) ? b2.HRESP     : b0.HRESP;
  assign rdat = (cur == 1) ? b2.HRDATA    : b0.HRDATA;

  ahb_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(8), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .bus(b0.slave));
  ahb_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(8), .WAIT_STATES(2)) u2 (
    .HCLK(clk), .HRESET(rst), .bus(b2.slave));

  int n_vec = 0;
  int n_err = 0;
  int ws    = 0;

  // reference memory: bytes, aliased modulo 256 words * 4 bytes
  bit [7:0] mdl [2][1024];

  bit          dp_v, dp_w, dp_e;
  logic [31:0] dp_wd, dp_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One AHB transfer, pipelined: this call's address phase overlaps the previous call's data phase.
  task automatic xfer(input bit idle, input bit w, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    int n;
    bit r1, e;
    hsel   = !idle;
    htrans = idle ? 2'b00 : 2'b10;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    hwdata = dp_wd;
    n  = 0;
    r1 = rsp;
    while (!rdy && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (dp_v) begin
      chk("wait_cycles", n, dp_e ? 1 : ws);
      chk("hresp", rsp, dp_e);
      if (dp_e) chk("err1_hresp", r1, 1);
      if (!dp_w && !dp_e) chk("hrdata", rdat, dp_exp);
    end
    @(posedge clk);
    e     = (sz > 3'd2) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
    dp_v  = !idle;
    dp_w  = w;
    dp_e  = e;
    dp_wd = wd;
    if (!idle && !e) begin
      if (w) begin
        for (int i = 0; i < (1 << sz); i++)
          mdl[cur][int'((a + i) & 32'h3FF)] = wd[8*(int'(a[1:0]) + i) +: 8];
      end else begin
        for (int i = 0; i < 4; i++)
          dp_exp[8*i +: 8] = mdl[cur][int'(((a & 32'h3FC) + i) & 32'h3FF)];
      end
    end
    @(negedge clk);
  endtask

  task automatic rnd(input int cnt);
    logic [2:0]  sz;
    logic [31:0] a;
    bit          idle, w;
    for (int k = 0; k < 16; k++) xfer(0, 1, 32'h100 + 4 * k, 3'd2, $urandom);
    for (int k = 0; k < cnt; k++) begin
      sz = 3'($urandom_range(0, 3));
      a  = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) a = a | 32'h400;
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      idle = ($urandom_range(0, 7) == 0);
      w    = 1'($urandom_range(0, 1));
      xfer(idle, w, a, sz, $urandom);
    end
    xfer(1, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hreadyout"}, rdy, 1);
    chk({tag, "_hresp"}, rsp, 0);
    chk({tag, "_hrdata"}, rdat, 0);
  endtask

  initial begin
    logic [31:0] keep;
    hsel = 0; htrans = 0; haddr = 0; hwrite = 0; hsize = 0; hwdata = 0;
    dp_v = 0; dp_w = 0; dp_e = 0; dp_wd = 0; dp_exp = 0;
    cur = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    cur = 0; chk_reset_outputs("rst_ws0");
    cur = 1; chk_reset_outputs("rst_ws2");
    cur = 0; ws = 0;

    // word write, immediate read (forwarded), later read (from array)
    xfer(0, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    xfer(0, 0, 32'h10, 3'd2, 0);
    xfer(1, 0, 0, 0, 0);
    // word then byte lane 2, read back both merged
    xfer(0, 1, 32'h20, 3'd2, 32'h11223344);
    xfer(0, 1, 32'h22, 3'd0, 32'h00AA0000);
    xfer(0, 0, 32'h20, 3'd2, 0);
    xfer(0, 0, 32'h10, 3'd2, 0);
    // misaligned word write errors and leaves memory alone
    xfer(0, 1, 32'h21, 3'd2, 32'hFFFFFFFF);
    xfer(0, 0, 32'h20, 3'd2, 0);
    // upper address bits alias onto word 0
    xfer(0, 1, 32'h400, 3'd2, 32'h5);
    xfer(0, 0, 32'h0, 3'd2, 0);
    xfer(1, 0, 0, 0, 0);

    // reset during a write data phase discards that write
    xfer(0, 1, 32'h30, 3'd2, 32'h12345678);
    xfer(1, 0, 0, 0, 0);
    keep = 32'h12345678;
    xfer(0, 1, 32'h30, 3'd2, 32'hCAFEF00D);
    hsel = 0; htrans = 0; hwdata = 32'hCAFEF00D;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk_reset_outputs("midrst");
    for (int i = 0; i < 4; i++) mdl[0][32'h30 + i] = keep[8*i +: 8];
    dp_v = 0; dp_wd = 0;
    xfer(0, 0, 32'h30, 3'd2, 0);
    xfer(1, 0, 0, 0, 0);

    rnd(80);

    // two wait-state instance
    cur = 1; ws = 2;
    xfer(0, 1, 32'h40, 3'd2, 32'hA5A55A5A);
    xfer(1, 0, 0, 0, 0);
    xfer(0, 0, 32'h40, 3'd2, 0);
    xfer(0, 1, 32'h43, 3'd0, 32'h7E000000);
    xfer(0, 0, 32'h40, 3'd2, 0);
    xfer(0, 1, 32'h42, 3'd2, 0);
    xfer(1, 0, 0, 0, 0);
    rnd(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1);
  end
endmodule
